// File: rtl/minstr_loader_pkg.sv
// Shared definitions for the instruction loader: opcodes, kind encoding, FSM states.
// Readback checking is enabled with the MINSTR_LOADER_READBACK_EN macro.
package minstr_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    KIND_R   = 2'b00,
    KIND_LW  = 2'b01,
    KIND_SW  = 2'b10,
    KIND_BEQ = 2'b11
  } kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_CHECK = 2'b10
  } state_t;

endpackage

// File: rtl/minstr_loader_encode.sv
// Combinational MIPS-style instruction encoder: kind plus register/immediate fields
// to a 32-bit instruction word.
module minstr_encode
  import minstr_loader_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  // Select the instruction format from the kind field
  always_comb begin
    word = 32'h0000_0000;
    case (kind)
      KIND_R:   word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_LW:  word = {OP_LW, rs, rt, imm};
      KIND_SW:  word = {OP_SW, rs, rt, imm};
      KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
      default:  word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/minstr_loader.sv
// Instruction-memory loader: accepts decoded instruction fields, encodes them and
// writes consecutive words from BASE_ADDR. MINSTR_LOADER_READBACK_EN adds a verify cycle.
module minstr_loader
  import minstr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic        last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  count,
  output logic        full,
  output logic        done,
  output logic        rb_err
);

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  state_t      state_r;
  state_t      nextState_s;
  logic [31:0] word_r;
  logic        last_r;
  logic [7:0]  count_r;
  logic        done_r;
  logic [31:0] encWord_s;
  logic        full_s;
  logic        accept_s;
  logic [7:0]  addrIdx_s;

  minstr_encode u_encode (
    .kind  (kind),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .funct (funct),
    .imm   (imm),
    .word  (encWord_s)
  );

  assign full_s   = (count_r == DEPTH_W);
  assign in_ready = (state_r == ST_IDLE) && !full_s && !done_r;
  assign accept_s = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic; clear always returns to IDLE
  always_comb begin
    nextState_s = state_r;
    if (clear) begin
      nextState_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            nextState_s = ST_WRITE;
          end else begin
            nextState_s = ST_IDLE;
          end
        end
`ifdef MINSTR_LOADER_READBACK_EN
        ST_WRITE: nextState_s = ST_CHECK;
`else
        ST_WRITE: nextState_s = ST_IDLE;
`endif
        ST_CHECK: nextState_s = ST_IDLE;
        default:  nextState_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; CHECK keeps pointing at the word just written (count already advanced)
  always_comb begin
    mem_we    = 1'b0;
    addrIdx_s = count_r;
    case (state_r)
      ST_WRITE: mem_we = 1'b1;
      ST_CHECK: addrIdx_s = count_r - 8'd1;
      default:  mem_we = 1'b0;
    endcase
  end

  assign mem_addr  = BASE_ADDR + {22'd0, addrIdx_s, 2'b00};
  assign mem_wdata = word_r;
  assign count     = count_r;
  assign full      = full_s;
  assign done      = done_r;

  // Datapath: captured word, load counter and sticky done
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r  <= 32'h0000_0000;
      last_r  <= 1'b0;
      count_r <= 8'd0;
      done_r  <= 1'b0;
    end else if (clear) begin
      count_r <= 8'd0;
      done_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        word_r <= encWord_s;
        last_r <= last;
      end
      if (state_r == ST_WRITE) begin
        count_r <= count_r + 8'd1;
        if (last_r) begin
          done_r <= 1'b1;
        end
      end
    end
  end

`ifdef MINSTR_LOADER_READBACK_EN
  logic rbErr_r;

  // Sticky readback mismatch flag, compared during the CHECK cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rbErr_r <= 1'b0;
    end else if ((state_r == ST_CHECK) && (mem_rdata != word_r)) begin
      rbErr_r <= 1'b1;
    end
  end

  assign rb_err = rbErr_r;
`else
  logic unusedRdata_s;
  assign unusedRdata_s = ^mem_rdata;
  assign rb_err        = 1'b0;
`endif

endmodule

// File: tb/tb_minstr_loader.sv
// Scoreboard bench for minstr_loader (DEPTH=4, BASE_ADDR=0); readback scenario runs
// only when MINSTR_LOADER_READBACK_EN is defined.
module tb_minstr_loader;
  import minstr_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  kind = 2'b00;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic [5:0]  funct = 6'd0;
  logic [15:0] imm = 16'd0;
  logic        last = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  count;
  logic        full, done, rb_err;

  int          nVec = 0;
  int          nFail = 0;
  logic [63:0] expQ[$];
  logic [63:0] expNow;
  logic [31:0] mem [16];
  logic        corrupt = 1'b0;

  always #5 clk = ~clk;

  minstr_loader #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .last(last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .count(count), .full(full), .done(done), .rb_err(rb_err)
  );

  // Memory model; optionally corrupts bit 0 of the word stored at 0x4
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:2]] <= (corrupt && mem_addr == 32'h4) ? (mem_wdata ^ 32'h1) : mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[5:2]];

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we) begin
      nVec++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_wdata);
      end else begin
        expNow = expQ.pop_front();
        if (mem_addr !== expNow[63:32] || mem_wdata !== expNow[31:0]) begin
          nFail++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, expNow[63:32], expNow[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic doReset;
    reset = 1'b1;
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one instruction, wait for acceptance, return during its WRITE cycle
  task automatic send(input logic [1:0] k, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [5:0] f, input logic [15:0] i,
                      input logic l, input logic [31:0] expAddr, input logic [31:0] expWord);
    bit got = 1'b0;
    kind = k; rs = a; rt = b; rd = c; funct = f; imm = i; last = l;
    in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      nVec++;
      nFail++;
      $display("FAIL send_timeout got=in_ready_low want=accept");
      in_valid = 1'b0;
    end else begin
      expQ.push_back({expAddr, expWord});
      @(posedge clk);
      #1 in_valid = 1'b0;
      last = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    doReset();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rb_err", {31'd0, rb_err}, 32'd0);

    // R-type add
    send(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h1234, 1'b0, 32'h0, 32'h0022_1820);
    chk("rtype_ready_in_write", {31'd0, in_ready}, 32'd0);
    chk("rtype_we_in_write", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1;
    chk("rtype_count", {24'd0, count}, 32'd1);
    chk("rtype_we_after", {31'd0, mem_we}, 32'd0);

    // lw then sw
    doReset();
    send(KIND_LW, 5'd29, 5'd8, 5'd31, 6'h3F, 16'd4, 1'b0, 32'h0, 32'h8FA8_0004);
    chk("lw_ready_in_write", {31'd0, in_ready}, 32'd0);
    send(KIND_SW, 5'd29, 5'd8, 5'd0, 6'h00, 16'd8, 1'b0, 32'h4, 32'hAFA8_0008);
    chk("sw_ready_in_write", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("lwsw_count", {24'd0, count}, 32'd2);

    // beq with last, further input ignored
    doReset();
    send(KIND_BEQ, 5'd1, 5'd2, 5'd7, 6'h11, 16'hFFFF, 1'b1, 32'h0, 32'h1022_FFFF);
    repeat (2) @(posedge clk); #1;
    chk("beq_done", {31'd0, done}, 32'd1);
    kind = KIND_R; rs = 5'd4; rt = 5'd5; rd = 5'd6; funct = 6'h22; in_valid = 1'b1;
    repeat (8) @(posedge clk); #1;
    in_valid = 1'b0;
    chk("beq_count_after", {24'd0, count}, 32'd1);
    chk("beq_ready_after", {31'd0, in_ready}, 32'd0);

    // in_valid held high fills DEPTH=4
    doReset();
    for (int n = 0; n < 4; n++) expQ.push_back({32'(n * 4), 32'h0022_1820});
    kind = KIND_R; rs = 5'd1; rt = 5'd2; rd = 5'd3; funct = 6'h20; in_valid = 1'b1;
    repeat (16) @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {24'd0, count}, 32'd4);
    chk("fill_ready", {31'd0, in_ready}, 32'd0);

    // clear during the third word's WRITE
    doReset();
    send(KIND_R, 5'd1, 5'd2, 5'd1, 6'h20, 16'd0, 1'b0, 32'h0, 32'h0022_0820);
    send(KIND_R, 5'd1, 5'd2, 5'd2, 6'h20, 16'd0, 1'b0, 32'h4, 32'h0022_1020);
    send(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 1'b1, 32'h8, 32'h0022_1820);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_count", {24'd0, count}, 32'd0);
    chk("clear_done", {31'd0, done}, 32'd0);
    chk("clear_addr", mem_addr, 32'h0);
    send(KIND_LW, 5'd29, 5'd8, 5'd0, 6'h00, 16'd4, 1'b0, 32'h0, 32'h8FA8_0004);
    repeat (3) @(posedge clk); #1;
    chk("clear_recount", {24'd0, count}, 32'd1);

`ifdef MINSTR_LOADER_READBACK_EN
    // readback catches a corrupted second word
    doReset();
    corrupt = 1'b1;
    send(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 1'b0, 32'h0, 32'h0022_1820);
    repeat (2) @(posedge clk); #1;
    chk("rb_first_ok", {31'd0, rb_err}, 32'd0);
    send(KIND_SW, 5'd29, 5'd8, 5'd0, 6'h00, 16'd8, 1'b0, 32'h4, 32'hAFA8_0008);
    repeat (2) @(posedge clk); #1;
    chk("rb_err_set", {31'd0, rb_err}, 32'd1);
    send(KIND_LW, 5'd29, 5'd8, 5'd0, 6'h00, 16'd4, 1'b0, 32'h8, 32'h8FA8_0004);
    repeat (3) @(posedge clk); #1;
    chk("rb_err_sticky", {31'd0, rb_err}, 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("rb_err_cleared", {31'd0, rb_err}, 32'd0);
    corrupt = 1'b0;
`else
    chk("rb_err_tied", {31'd0, rb_err}, 32'd0);
`endif

    repeat (3) @(posedge clk); #1;
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
